// File: rtl/pipe_traffic_ctrl_n.sv
// pipe_traffic_ctrl_n: hazard/flush controller for an N-stage in-order pipeline.
// Index 0 is fetch and index NUM_STAGES-1 is the retire stage.
// Optional feature macro: PIPE_TRAFFIC_PERF_CNT_EN. When it is defined, the two
// performance counters are built. When it is not defined, both counter ports are tied to 0.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   stage_stall          - per-stage "cannot complete this cycle"
//   flush_req            - per-stage redirect; squashes all younger stages (bit 0 ignored)
//   stage_wr_en          - per-stage pipeline register load enable (combinational)
//   stage_gen_bubble     - per-stage "load a bubble" when written (combinational, bit 0 = 0)
//   stage_valid          - registered per-stage valid bits
//   stall_timeout        - sticky retire-stall watchdog flag
//   perf_stall_cycles    - cycles with fetch stalled (optional)
//   perf_flush_count     - completed flushes (optional)
module pipe_traffic_ctrl_n #(
    parameter int unsigned NUM_STAGES    = 5,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned PERF_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stage_stall,
    input  logic [NUM_STAGES-1:0] flush_req,
    output logic [NUM_STAGES-1:0] stage_wr_en,
    output logic [NUM_STAGES-1:0] stage_gen_bubble,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  stall_timeout,
    output logic [PERF_W-1:0]     perf_stall_cycles,
    output logic [PERF_W-1:0]     perf_flush_count
);

    localparam int unsigned N     = NUM_STAGES;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

    logic [N-1:0]     wr_chain;
    logic             flush_active;
    logic [IDX_W-1:0] flush_idx;
    logic [N-1:0]     valid_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_nxt;

    // Stall chain, oldest-wins flush select, and the flush/reset overrides
    always_comb begin
        wr_chain         = '0;
        flush_active     = 1'b0;
        flush_idx        = '0;
        stage_wr_en      = '0;
        stage_gen_bubble = '0;

        wr_chain[N-1] = ~stage_stall[N-1];
        for (int k = int'(N) - 2; k >= 0; k--) begin
            wr_chain[k] = wr_chain[k+1] & ~stage_stall[k];
        end

        // The scan runs upward, so the last hit is the oldest requester
        for (int k = 1; k < int'(N); k++) begin
            if (flush_req[k]) begin
                flush_active = 1'b1;
                flush_idx    = IDX_W'(k);
            end
        end

        stage_wr_en = wr_chain;
        for (int k = 1; k < int'(N); k++) begin
            stage_gen_bubble[k] = stage_stall[k-1] | ~stage_valid[k-1];
        end

        // The flushing stage keeps its chain enable, so a stalled flusher holds and re-issues the flush
        if (flush_active) begin
            for (int k = 0; k < int'(N); k++) begin
                if (k < int'(flush_idx)) begin
                    stage_wr_en[k] = 1'b1;
                end
                if ((k >= 1) && (k <= int'(flush_idx))) begin
                    stage_gen_bubble[k] = 1'b1;
                end
            end
        end

        if (reset) begin
            stage_wr_en      = '1;
            stage_gen_bubble = {{(N-1){1'b1}}, 1'b0};
        end
    end

    // Next valid bits: written stages take the older valid unless a bubble is loaded
    always_comb begin
        valid_nxt = stage_valid;
        if (stage_wr_en[0]) begin
            valid_nxt[0] = 1'b1;
        end
        for (int k = 1; k < int'(N); k++) begin
            if (stage_wr_en[k]) begin
                valid_nxt[k] = stage_gen_bubble[k] ? 1'b0 : stage_valid[k-1];
            end
        end
    end

    // Saturating count of consecutive cycles in which the retire stage did not load
    always_comb begin
        wd_cnt_nxt = wd_cnt;
        if (stage_wr_en[N-1]) begin
            wd_cnt_nxt = '0;
        end else if (wd_cnt != CNT_W'(STALL_TIMEOUT)) begin
            wd_cnt_nxt = wd_cnt + CNT_W'(1);
        end
    end

    // Valid, watchdog and sticky timeout registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid   <= '0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stage_valid <= valid_nxt;
            wd_cnt      <= wd_cnt_nxt;
            if (wd_cnt_nxt == CNT_W'(STALL_TIMEOUT)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_TRAFFIC_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // A flush is counted only on the cycle the flushing stage actually advances
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!stage_wr_en[0]) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (flush_active && stage_wr_en[flush_idx]) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cycles = stall_cnt;
    assign perf_flush_count  = flush_cnt;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_traffic_ctrl_n.sv
// tb_pipe_traffic_ctrl_n: directed self-checking bench for pipe_traffic_ctrl_n (N=5, STALL_TIMEOUT=4).
module tb_pipe_traffic_ctrl_n;

    localparam int unsigned N  = 5;
    localparam int unsigned TO = 4;
    localparam int unsigned PW = 32;

    logic          clk;
    logic          reset;
    logic [N-1:0]  stage_stall;
    logic [N-1:0]  flush_req;
    logic [N-1:0]  stage_wr_en;
    logic [N-1:0]  stage_gen_bubble;
    logic [N-1:0]  stage_valid;
    logic          stall_timeout;
    logic [PW-1:0] perf_stall_cycles;
    logic [PW-1:0] perf_flush_count;

    int unsigned n_checks;
    int unsigned n_errors;

    pipe_traffic_ctrl_n #(
        .NUM_STAGES   (N),
        .STALL_TIMEOUT(TO),
        .PERF_W       (PW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stage_stall      (stage_stall),
        .flush_req        (flush_req),
        .stage_wr_en      (stage_wr_en),
        .stage_gen_bubble (stage_gen_bubble),
        .stage_valid      (stage_valid),
        .stall_timeout    (stall_timeout),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        stage_stall = '0;
        flush_req   = '0;

        // Reset: all write, bubbles everywhere except fetch
        #1;
        check("rst_wr_en",  32'(stage_wr_en),      32'h1F);
        check("rst_bubble", 32'(stage_gen_bubble), 32'h1E);
        tick();
        check("rst_valid",   32'(stage_valid),   32'h00);
        check("rst_timeout", 32'(stall_timeout), 32'h0);
        check("rst_perf_s",  perf_stall_cycles,  32'h0);
        check("rst_perf_f",  perf_flush_count,   32'h0);

        // Fill from empty
        reset = 1'b0;
        #1;
        check("fill_wr_en",  32'(stage_wr_en),      32'h1F);
        check("fill_bubble", 32'(stage_gen_bubble), 32'h1E);
        tick(); check("fill_v1", 32'(stage_valid), 32'h01);
        tick(); check("fill_v2", 32'(stage_valid), 32'h03);
        tick(); check("fill_v3", 32'(stage_valid), 32'h07);
        tick(); check("fill_v4", 32'(stage_valid), 32'h0F);
        tick(); check("fill_v5", 32'(stage_valid), 32'h1F);

        // EX stall for three cycles
        stage_stall = 5'b00100;
        #1;
        check("exst_wr_en",  32'(stage_wr_en),      32'h18);
        check("exst_bubble", 32'(stage_gen_bubble), 32'h08);
        tick(); check("exst_v1", 32'(stage_valid), 32'h17);
        check("exst_bubble2", 32'(stage_gen_bubble), 32'h18);
        tick();
        tick(); check("exst_v3", 32'(stage_valid), 32'h07);
        stage_stall = '0;
        #1;
        check("exst_rel_bubble", 32'(stage_gen_bubble), 32'h10);
        tick(); check("exst_rel_v1", 32'(stage_valid), 32'h0F);
        tick(); check("exst_rel_v2", 32'(stage_valid), 32'h1F);

        // Flush from EX on a full pipe
        flush_req = 5'b00100;
        #1;
        check("fl2_wr_en",  32'(stage_wr_en),      32'h1F);
        check("fl2_bubble", 32'(stage_gen_bubble), 32'h06);
        tick(); check("fl2_valid", 32'(stage_valid), 32'h19);
        flush_req = '0;
        #1;
        check("fl2_refill_bubble", 32'(stage_gen_bubble), 32'h0C);
        tick(); check("fl2_refill_v1", 32'(stage_valid), 32'h13);
        tick(); check("fl2_refill_v2", 32'(stage_valid), 32'h07);
        tick(); check("fl2_refill_v3", 32'(stage_valid), 32'h0F);
        tick(); check("fl2_refill_v4", 32'(stage_valid), 32'h1F);

        // Two requesters, oldest (retire) wins while the retire stage is stalled
        flush_req   = 5'b10100;
        stage_stall = 5'b10000;
        #1;
        check("fl4_wr_en",  32'(stage_wr_en),      32'h0F);
        check("fl4_bubble", 32'(stage_gen_bubble), 32'h1E);
        tick(); check("fl4_v1", 32'(stage_valid), 32'h11);
        tick(); check("fl4_v2", 32'(stage_valid), 32'h11);
`ifdef PIPE_TRAFFIC_PERF_CNT_EN
        check("fl4_held_cnt", perf_flush_count, 32'd0);
`endif
        stage_stall = '0;
        #1;
        check("fl4_rel_wr_en", 32'(stage_wr_en), 32'h1F);
        tick(); check("fl4_rel_valid", 32'(stage_valid), 32'h01);
`ifdef PIPE_TRAFFIC_PERF_CNT_EN
        check("fl4_done_cnt", perf_flush_count, 32'd1);
`endif
        check("fl4_timeout", 32'(stall_timeout), 32'h0);
        flush_req = '0;

        // Watchdog: retire stall held for STALL_TIMEOUT edges
        stage_stall = 5'b10000;
        #1;
        check("wd_wr_en", 32'(stage_wr_en), 32'h00);
        tick(); tick(); tick();
        check("wd_edge3", 32'(stall_timeout), 32'h0);
        tick();
        check("wd_edge4", 32'(stall_timeout), 32'h1);
        check("wd_hold_valid", 32'(stage_valid), 32'h01);
        stage_stall = '0;
        tick();
        tick();
        check("wd_sticky", 32'(stall_timeout), 32'h1);
        check("wd_rel_valid", 32'(stage_valid), 32'h07);
`ifdef PIPE_TRAFFIC_PERF_CNT_EN
        check("perf_stall", perf_stall_cycles, 32'd7);
        check("perf_flush", perf_flush_count,  32'd1);
`else
        check("perf_stall_off", perf_stall_cycles, 32'd0);
        check("perf_flush_off", perf_flush_count,  32'd0);
`endif

        // Same stage stalls and flushes: only younger stages are forced
        stage_stall = 5'b01000;
        flush_req   = 5'b01000;
        #1;
        check("same_wr_en",  32'(stage_wr_en),      32'h17);
        check("same_bubble", 32'(stage_gen_bubble), 32'h1E);

        // Reset overrides an active flush and stall
        stage_stall = 5'b00100;
        flush_req   = 5'b01000;
        reset       = 1'b1;
        #1;
        check("mid_rst_wr_en",  32'(stage_wr_en),      32'h1F);
        check("mid_rst_bubble", 32'(stage_gen_bubble), 32'h1E);
        tick();
        check("mid_rst_valid",   32'(stage_valid),   32'h00);
        check("mid_rst_timeout", 32'(stall_timeout), 32'h0);
        check("mid_rst_perf_s",  perf_stall_cycles,  32'h0);
        check("mid_rst_perf_f",  perf_flush_count,   32'h0);
        reset       = 1'b0;
        stage_stall = '0;
        flush_req   = '0;
        tick();
        check("post_rst_valid", 32'(stage_valid), 32'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
